tag_lookup: RTL and testbench
=============================

// Module: tag_lookup
// PURPOSE
//  Direct-mapped cache tag/state store and hit-detection stage, directly downstream of the
//  address decoder. Takes {index, tag} per request, reads tag/valid/dirty for that set,
//  returns hit/miss plus victim info through a registered, back-pressurable response.
//  Also has a maintenance port used by the fill/writeback controller to fill,
//  invalidate or clean a set.
// PARAMETERS
//  ADDR_SIZE   32  byte-address width
//  BLOCK_SIZE  6   block-offset bits (64 B line)
//  INDEX_SIZE  7   set-index bits (128 sets)
//  TAG_SIZE    ADDR_SIZE-BLOCK_SIZE-INDEX_SIZE (19)  stored tag width
// PORTS
//  clk             in   1           single clock, all state on rising edge
//  rst             in   1           synchronous, active-high reset
//  req_valid       in   1           lookup request valid
//  req_ready       out  1           lookup request accepted when valid&ready
//  req_index       in   INDEX_SIZE  set index from address decoder
//  req_tag         in   TAG_SIZE    tag from address decoder
//  req_write       in   1           store request: set dirty bit on hit
//  rsp_valid       out  1           response valid
//  rsp_ready       in   1           consumer accepts response
//  rsp_hit         out  1           valid[idx] && tag[idx]==req_tag
//  rsp_dirty       out  1           dirty bit of resident line (pre-update value)
//  rsp_victim_tag  out  TAG_SIZE    tag resident at idx (meaningful on miss with dirty)
//  rsp_index       out  INDEX_SIZE  echoed request index
//  upd_valid       in   1           maintenance op valid (single-cycle, always accepted in RUN)
//  upd_index       in   INDEX_SIZE  maintenance set
//  upd_tag         in   TAG_SIZE    tag written on fill
//  upd_op          in   2           00 fill clean, 01 fill dirty, 10 invalidate, 11 clean
//  init_done       out  1           high once invalidation sweep complete
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_hit=0, rsp_dirty=0, rsp_victim_tag=0,
//    rsp_index=0, init_done=0, sweep counter=0, state=INIT. Tag array contents not reset.
//  - FSM INIT: clear valid/dirty of set[cnt], cnt++ each cycle; req_ready=0, upd ignored.
//    At cnt==2^INDEX_SIZE-1 clear it and go RUN (INIT lasts exactly 2^INDEX_SIZE cycles);
//    init_done=1 from first RUN cycle, stays 1 until rst.
//  - RUN: req_ready = !upd_valid && (!rsp_valid || rsp_ready). Combinational; no
//    dependency on req_valid.
//  - Accept (req_valid&&req_ready) at edge N: rsp_* registered at edge N, rsp_valid=1
//    from cycle N+1 (latency 1). Back-to-back accepts give one response per cycle.
//  - rsp_valid&&!rsp_ready: all rsp_* held stable; no new accept.
//  - rsp_valid drops after rsp_ready handshake unless a new accept on the same edge.
//  - Write hit: dirty[idx] set on accept edge; rsp_dirty reports the value before that edge.
//    Write miss or read: no state change (allocation is controller's job via upd).
//  - upd in RUN: applied at edge; fill sets valid=1, tag=upd_tag, dirty=op[0];
//    invalidate clears valid and dirty; clean clears dirty only.
//    upd has priority: req_ready forced 0 that cycle, so no same-cycle lookup/update
//    conflict. A lookup accepted the cycle after an update sees the updated state.
//  - rst asserted in any state/cycle: next cycle equals reset state, the in-flight
//    response is dropped, and the sweep restarts at set 0.
//  - Index wrap: sweep counter width INDEX_SIZE; the terminal compare is used and the
//    counter never overflows into a second pass.
// TESTING
//  1 rst 1 cycle -> init_done=0 for 128 cycles, rises on cycle 129; req_ready 0 throughout INIT.
//  2 lookup idx 5 tag 0x1234 after init -> next cycle rsp_valid=1, hit=0, dirty=0, rsp_index=5.
//  3 upd fill-clean idx 5 tag 0x1234, then write lookup, then read lookup -> hit=1/dirty=0,
//    then hit=1/dirty=1.
//  4 rsp_ready=0 for 3 cycles with req_valid held -> rsp_* stable, req_ready=0,
//    single accept after release.
//  5 upd_valid and req_valid same cycle idx 9 -> req_ready=0; request accepted next cycle
//    and sees the filled tag.
//  6 rst mid-stream with rsp_valid=1 -> rsp_valid=0 next cycle, full 128-cycle sweep rerun,
//    prior fills miss.

Source files
------------

// File: rtl/tag_lookup.sv
`default_nettype none
// ============================================================================
// Module   : tag_lookup
// Brief    : Direct-mapped cache tag/state store with registered, back-
//            pressurable hit/miss response and a fill/invalidate/clean port.
// Revision : 1.0 - initial release
// ============================================================================
module tag_lookup #(
    parameter int ADDR_SIZE  = 32,
    parameter int BLOCK_SIZE = 6,
    parameter int INDEX_SIZE = 7,
    parameter int TAG_SIZE   = ADDR_SIZE - BLOCK_SIZE - INDEX_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INDEX_SIZE-1:0] req_index,
    input  logic [TAG_SIZE-1:0]   req_tag,
    input  logic                  req_write,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic                  rsp_dirty,
    output logic [TAG_SIZE-1:0]   rsp_victim_tag,
    output logic [INDEX_SIZE-1:0] rsp_index,
    input  logic                  upd_valid,
    input  logic [INDEX_SIZE-1:0] upd_index,
    input  logic [TAG_SIZE-1:0]   upd_tag,
    input  logic [1:0]            upd_op,
    output logic                  init_done
);

    localparam int                  c_num_sets = 1 << INDEX_SIZE;
    localparam logic [INDEX_SIZE-1:0] c_last_set = '1;

    localparam logic [1:0] c_op_fill_clean = 2'b00;
    localparam logic [1:0] c_op_fill_dirty = 2'b01;
    localparam logic [1:0] c_op_invalidate = 2'b10;
    localparam logic [1:0] c_op_clean      = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [INDEX_SIZE-1:0]   r_cnt;

    logic [TAG_SIZE-1:0]     r_tag_mem [c_num_sets];
    logic [c_num_sets-1:0]   r_valid;
    logic [c_num_sets-1:0]   r_dirty;

    logic                    r_rsp_valid;
    logic                    r_rsp_hit;
    logic                    r_rsp_dirty;
    logic [TAG_SIZE-1:0]     r_rsp_victim_tag;
    logic [INDEX_SIZE-1:0]   r_rsp_index;

    logic                    w_req_ready;
    logic                    w_accept;
    logic                    w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == c_last_set) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Maintenance owns the arrays this cycle, so lookups stall.
                w_req_ready = !upd_valid && (!r_rsp_valid || rsp_ready);
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_accept = req_valid && w_req_ready;
    assign w_hit    = r_valid[req_index] && (r_tag_mem[req_index] == req_tag);

    // Tag storage is never reset; only valid/dirty are swept.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_RUN) && upd_valid && !upd_op[1]) begin
            r_tag_mem[upd_index] <= upd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // sweep restarts next cycle and clears every set
        end else if (r_state == ST_INIT) begin
            r_valid[r_cnt] <= 1'b0;
            r_dirty[r_cnt] <= 1'b0;
        end else begin
            if (upd_valid) begin
                case (upd_op)
                    c_op_fill_clean: begin
                        r_valid[upd_index] <= 1'b1;
                        r_dirty[upd_index] <= 1'b0;
                    end
                    c_op_fill_dirty: begin
                        r_valid[upd_index] <= 1'b1;
                        r_dirty[upd_index] <= 1'b1;
                    end
                    c_op_invalidate: begin
                        r_valid[upd_index] <= 1'b0;
                        r_dirty[upd_index] <= 1'b0;
                    end
                    c_op_clean: begin
                        r_dirty[upd_index] <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (w_accept && req_write && w_hit) begin
                r_dirty[req_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid      <= 1'b0;
            r_rsp_hit        <= 1'b0;
            r_rsp_dirty      <= 1'b0;
            r_rsp_victim_tag <= '0;
            r_rsp_index      <= '0;
        end else if (w_accept) begin
            r_rsp_valid      <= 1'b1;
            r_rsp_hit        <= w_hit;
            r_rsp_dirty      <= r_dirty[req_index];
            r_rsp_victim_tag <= r_tag_mem[req_index];
            r_rsp_index      <= req_index;
        end else if (rsp_ready) begin
            r_rsp_valid      <= 1'b0;
        end
    end

    assign req_ready      = w_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_hit        = r_rsp_hit;
    assign rsp_dirty      = r_rsp_dirty;
    assign rsp_victim_tag = r_rsp_victim_tag;
    assign rsp_index      = r_rsp_index;
    assign init_done      = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_tag_lookup.sv
`default_nettype none
// ============================================================================
// Module   : tb_tag_lookup
// Brief    : Self-checking bench for tag_lookup with a set-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tag_lookup;

    localparam int c_sets = 128;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_index;
    logic [18:0] req_tag;
    logic        req_write;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic        rsp_dirty;
    logic [18:0] rsp_victim_tag;
    logic [6:0]  rsp_index;
    logic        upd_valid;
    logic [6:0]  upd_index;
    logic [18:0] upd_tag;
    logic [1:0]  upd_op;
    logic        init_done;

    tag_lookup dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_tag(req_tag), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_dirty(rsp_dirty), .rsp_victim_tag(rsp_victim_tag), .rsp_index(rsp_index),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_tag(upd_tag),
        .upd_op(upd_op), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-set state plus the expected response register.
    logic [18:0] m_tag   [c_sets];
    bit          m_valid [c_sets];
    bit          m_dirty [c_sets];
    bit          m_known [c_sets];
    int          init_left;
    bit          e_valid, e_hit, e_dirty, e_vknown;
    logic [18:0] e_vtag;
    logic [6:0]  e_index;

    function automatic bit exp_ready();
        return (init_left == 0) && !upd_valid && (!e_valid || rsp_ready);
    endfunction

    task automatic model_edge();
        bit acc;
        bit hit;
        if (rst) begin
            e_valid = 0; e_hit = 0; e_dirty = 0; e_vtag = '0; e_vknown = 1; e_index = '0;
            init_left = c_sets;
            for (int i = 0; i < c_sets; i++) begin
                m_valid[i] = 0;
                m_dirty[i] = 0;
            end
            return;
        end
        if (init_left > 0) begin
            init_left--;
            return;
        end
        acc = req_valid && exp_ready();
        if (upd_valid) begin
            case (upd_op)
                2'b00, 2'b01: begin
                    m_valid[upd_index] = 1;
                    m_dirty[upd_index] = upd_op[0];
                    m_tag[upd_index]   = upd_tag;
                    m_known[upd_index] = 1;
                end
                2'b10: begin
                    m_valid[upd_index] = 0;
                    m_dirty[upd_index] = 0;
                end
                default: m_dirty[upd_index] = 0;
            endcase
        end
        if (acc) begin
            hit      = m_valid[req_index] && (m_tag[req_index] == req_tag);
            e_valid  = 1;
            e_hit    = hit;
            e_dirty  = m_dirty[req_index];
            e_vtag   = m_tag[req_index];
            e_vknown = m_known[req_index];
            e_index  = req_index;
            if (req_write && hit) m_dirty[req_index] = 1;
        end else if (rsp_ready) begin
            e_valid = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_index = '0; req_tag = '0;
        upd_valid = 0; upd_index = '0; upd_tag = '0; upd_op = 2'b00;
        rsp_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_dirty !== 1'b0 ||
            rsp_victim_tag !== 19'd0 || rsp_index !== 7'd0 || init_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got v=%b h=%b d=%b vt=%h idx=%0d init=%b, want all 0",
                     rsp_valid, rsp_hit, rsp_dirty, rsp_victim_tag, rsp_index, init_done);
        end
        req_valid = 1; req_index = 7'd3; req_tag = 19'h5;
        for (int i = 0; i < c_sets; i++) begin
            #1;
            n_vec++;
            if (init_done !== 1'b0 || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL init_sweep cycle %0d: init_done=%b req_ready=%b, want 0/0",
                         i, init_done, req_ready);
            end
            tick();
        end
        req_valid = 0;
        n_vec++;
        if (init_done !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL init_done_rise: init_done=%b rsp_valid=%b, want 1/0", init_done, rsp_valid);
        end
    endtask

    task automatic test_miss();
        req_valid = 1; req_write = 0; req_index = 7'd5; req_tag = 19'h1234;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL miss_ready: got %b want 1", req_ready);
        end
        tick();
        req_valid = 0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_dirty !== 1'b0 || rsp_index !== 7'd5) begin
            n_err++;
            $display("FAIL miss_rsp: got v=%b h=%b d=%b idx=%0d want 1/0/0/5",
                     rsp_valid, rsp_hit, rsp_dirty, rsp_index);
        end
        tick();
    endtask

    task automatic test_fill_hit();
        upd_valid = 1; upd_index = 7'd5; upd_tag = 19'h1234; upd_op = 2'b00;
        tick();
        upd_valid = 0;
        req_valid = 1; req_write = 1; req_index = 7'd5; req_tag = 19'h1234;
        tick();
        req_write = 0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_dirty !== 1'b0) begin
            n_err++;
            $display("FAIL write_hit: got v=%b h=%b d=%b want 1/1/0", rsp_valid, rsp_hit, rsp_dirty);
        end
        tick();
        req_valid = 0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_dirty !== 1'b1 ||
            rsp_victim_tag !== 19'h1234) begin
            n_err++;
            $display("FAIL read_after_write: got v=%b h=%b d=%b vt=%h want 1/1/1/01234",
                     rsp_valid, rsp_hit, rsp_dirty, rsp_victim_tag);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 0;
        req_valid = 1; req_index = 7'd20; req_tag = 19'h77;
        tick();
        req_index = 7'd21; req_tag = 19'h78;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_ready cycle %0d: got %b want 0", i, req_ready);
            end
            tick();
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_index !== 7'd20 || rsp_hit !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: v=%b idx=%0d h=%b want 1/20/0",
                         i, rsp_valid, rsp_index, rsp_hit);
            end
        end
        rsp_ready = 1;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready: got %b want 1", req_ready);
        end
        tick();
        req_valid = 0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_index !== 7'd21) begin
            n_err++;
            $display("FAIL release_accept: v=%b idx=%0d want 1/21", rsp_valid, rsp_index);
        end
        tick();
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_accept: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_upd_priority();
        upd_valid = 1; upd_index = 7'd9; upd_tag = 19'h4abc; upd_op = 2'b01;
        req_valid = 1; req_index = 7'd9; req_tag = 19'h4abc; req_write = 0;
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL upd_blocks_req: req_ready=%b want 0", req_ready);
        end
        tick();
        upd_valid = 0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_after_upd_ready: req_ready=%b want 1", req_ready);
        end
        tick();
        req_valid = 0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_dirty !== 1'b1 || rsp_index !== 7'd9) begin
            n_err++;
            $display("FAIL req_after_upd_rsp: v=%b h=%b d=%b idx=%0d want 1/1/1/9",
                     rsp_valid, rsp_hit, rsp_dirty, rsp_index);
        end
        tick();
    endtask

    task automatic test_random();
        bit er;
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_write = $urandom_range(0, 1);
            req_index = 7'($urandom_range(0, 7));
            req_tag   = 19'($urandom_range(0, 3));
            upd_valid = ($urandom_range(0, 4) == 0);
            upd_index = 7'($urandom_range(0, 7));
            upd_tag   = 19'($urandom_range(0, 3));
            upd_op    = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            er = exp_ready();
            n_vec++;
            if (req_ready !== er) begin
                n_err++;
                $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, er);
            end
            tick();
            n_vec++;
            if (rsp_valid !== e_valid || init_done !== 1'b1) begin
                n_err++;
                $display("FAIL rand_valid c%0d: v=%b init=%b want %b/1", c, rsp_valid, init_done, e_valid);
            end
            if (e_valid) begin
                n_vec++;
                if (rsp_hit !== e_hit || rsp_dirty !== e_dirty || rsp_index !== e_index ||
                    (e_vknown && rsp_victim_tag !== e_vtag)) begin
                    n_err++;
                    $display("FAIL rand_rsp c%0d: h=%b d=%b idx=%0d vt=%h want %b/%b/%0d/%h",
                             c, rsp_hit, rsp_dirty, rsp_index, rsp_victim_tag,
                             e_hit, e_dirty, e_index, e_vtag);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mid_reset();
        upd_valid = 1; upd_index = 7'd33; upd_tag = 19'h2222; upd_op = 2'b00;
        tick();
        upd_valid = 0;
        rsp_ready = 0;
        req_valid = 1; req_index = 7'd33; req_tag = 19'h2222;
        tick();
        req_valid = 0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_hit: v=%b h=%b want 1/1", rsp_valid, rsp_hit);
        end
        rst = 1;
        tick();
        rst = 0;
        rsp_ready = 1;
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || init_done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_drop: v=%b h=%b init=%b want 0/0/0", rsp_valid, rsp_hit, init_done);
        end
        for (int i = 0; i < c_sets; i++) begin
            n_vec++;
            if (init_done !== 1'b0) begin
                n_err++;
                $display("FAIL resweep cycle %0d: init_done=%b want 0", i, init_done);
            end
            tick();
        end
        n_vec++;
        if (init_done !== 1'b1) begin
            n_err++;
            $display("FAIL resweep_done: init_done=%b want 1", init_done);
        end
        req_valid = 1; req_index = 7'd33; req_tag = 19'h2222;
        tick();
        req_index = 7'd5; req_tag = 19'h1234;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_index !== 7'd33) begin
            n_err++;
            $display("FAIL post_reset_miss33: v=%b h=%b idx=%0d want 1/0/33", rsp_valid, rsp_hit, rsp_index);
        end
        tick();
        req_valid = 0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_dirty !== 1'b0 || rsp_index !== 7'd5) begin
            n_err++;
            $display("FAIL post_reset_miss5: v=%b h=%b d=%b idx=%0d want 1/0/0/5",
                     rsp_valid, rsp_hit, rsp_dirty, rsp_index);
        end
        tick();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        init_left = c_sets;
        e_valid = 0; e_hit = 0; e_dirty = 0; e_vtag = '0; e_vknown = 1; e_index = '0;
        @(negedge clk);
        test_reset();
        test_miss();
        test_fill_hit();
        test_backpressure();
        test_upd_priority();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
